// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage. Runs one load or store per instruction
//               over a single-outstanding req/ack bus and stalls upstream
//               until the access completes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [31:0]     i_inst,
    input  logic            i_memread,
    input  logic            i_memwrite,
    output logic            o_bus_en,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [3:0]      o_bus_be,
    output logic [XLEN-1:0] o_bus_wdata,
    input  logic [XLEN-1:0] i_bus_rdata,
    input  logic            i_bus_ack,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_misaligned,
    output logic            o_stall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [2:0]      r_f3;
    logic [1:0]      r_addr_lo;
    logic [2:0]      w_f3;
    logic            w_req;
    logic            w_misal;
    logic            w_start;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic            w_unused;

    assign w_f3     = i_inst[14:12];
    assign w_req    = i_memread | i_memwrite;
    assign w_start  = (r_state == S_IDLE) && w_req && !w_misal;
    assign w_unused = ^{i_inst[31:15], i_inst[11:0]};

    // Access size is encoded in f3[1:0]; the unused size code behaves as a byte.
    always_comb begin
        w_misal = 1'b0;
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {(XLEN/8){i_wr_data[7:0]}};
        case (w_f3[1:0])
            2'b01: begin
                w_misal = i_addr[0];
                w_be    = 4'b0011 << i_addr[1:0];
                w_wdata = {(XLEN/16){i_wr_data[15:0]}};
            end
            2'b10: begin
                w_misal = |i_addr[1:0];
                w_be    = 4'b1111;
                w_wdata = i_wr_data;
            end
            default: ;
        endcase
    end

    assign w_byte = i_bus_rdata[{r_addr_lo, 3'b000} +: 8];
    assign w_half = i_bus_rdata[{r_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = {{(XLEN-8){1'b0}}, w_byte};
        case (r_f3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            3'b010:  w_load_data = i_bus_rdata;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_BUSY;
            S_BUSY:  if (i_bus_ack) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // DONE releases the stall for exactly one cycle so upstream advances once.
    always_comb begin
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_misaligned = w_req & w_misal;
                o_stall      = w_req & ~w_misal;
            end
            S_BUSY:  o_stall = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_bus_en    <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_be    <= 4'b0000;
            o_bus_wdata <= '0;
            o_rd_data   <= '0;
            r_f3        <= 3'b000;
            r_addr_lo   <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        o_bus_en    <= 1'b1;
                        o_bus_we    <= i_memwrite;
                        o_bus_addr  <= {i_addr[XLEN-1:2], 2'b00};
                        o_bus_be    <= w_be;
                        o_bus_wdata <= w_wdata;
                        r_f3        <= w_f3;
                        r_addr_lo   <= i_addr[1:0];
                    end
                end
                S_BUSY: begin
                    if (i_bus_ack) begin
                        o_bus_en <= 1'b0;
                        if (!o_bus_we) o_rd_data <= w_load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed and randomized self-checking bench for mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] addr, wr_data, bus_rdata;
    logic [31:0]     inst;
    logic            memread, memwrite, bus_ack;
    logic            bus_en, bus_we, misaligned, stall;
    logic [XLEN-1:0] bus_addr, bus_wdata, rd_data;
    logic [3:0]      bus_be;

    int          vectors   = 0;
    int          errors    = 0;
    int          txn_count = 0;
    logic [31:0] model_rd  = 32'h0;

    mem_stage #(.XLEN(XLEN)) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_addr       (addr),
        .i_wr_data    (wr_data),
        .i_inst       (inst),
        .i_memread    (memread),
        .i_memwrite   (memwrite),
        .o_bus_en     (bus_en),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_be     (bus_be),
        .o_bus_wdata  (bus_wdata),
        .i_bus_rdata  (bus_rdata),
        .i_bus_ack    (bus_ack),
        .o_rd_data    (rd_data),
        .o_misaligned (misaligned),
        .o_stall      (stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus_en && bus_ack) txn_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes from f3 and plain arithmetic on it.
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b01) return 2;
        if (f3[1:0] == 2'b10) return 4;
        return 1;
    endfunction

    function automatic bit exp_misal(input logic [31:0] a, input logic [2:0] f3);
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] exp_be(input logic [31:0] a, input logic [2:0] f3);
        int v;
        v = ((1 << size_of(f3)) - 1) << (a % 4);
        return 32'(v & 15);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++)
            r = r | (((wd >> (8 * (i % size_of(f3)))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3,
                                             input logic [31:0] rdata);
        longint v;
        int     off, nbytes;
        bit     sgn;
        if (f3 == 3'b010) return rdata;
        off    = int'(a % 4);
        nbytes = (f3 == 3'b001 || f3 == 3'b101) ? 2 : 1;
        sgn    = (f3 == 3'b000 || f3 == 3'b001);
        v = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * nbytes)) - 1);
        if (sgn && v >= (longint'(1) << (8 * nbytes - 1))) v = v - (longint'(1) << (8 * nbytes));
        return v[31:0];
    endfunction

    task automatic set_idle();
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                          input logic [2:0] f3, input logic rd, input logic wr, input int waits,
                          input bit release_bus);
        int stall_cnt;
        addr = a; wr_data = wd; inst = {17'h0, f3, 12'h003}; memread = rd; memwrite = wr;
        @(negedge clk);
        if (!rd && !wr) begin
            check("idle_stall", 32'(stall), 32'h0);
            check("idle_misal", 32'(misaligned), 32'h0);
            @(posedge clk); #1;
            return;
        end
        if (exp_misal(a, f3)) begin
            check("misal_flag", 32'(misaligned), 32'h1);
            check("misal_stall", 32'(stall), 32'h0);
            @(posedge clk); #1;
            check("misal_no_en", 32'(bus_en), 32'h0);
            set_idle();
            return;
        end
        check("req_misal", 32'(misaligned), 32'h0);
        check("req_stall", 32'(stall), 32'h1);
        stall_cnt = 1;
        @(posedge clk); #1;
        for (int w = 0; w <= waits; w++) begin
            if (w == waits) begin bus_ack = 1'b1; bus_rdata = rdata; end
            else bus_rdata = $urandom;
            @(negedge clk);
            check("bus_en", 32'(bus_en), 32'h1);
            check("bus_we", 32'(bus_we), 32'(wr));
            check("bus_addr", bus_addr, {a[31:2], 2'b00});
            check("bus_be", 32'(bus_be), exp_be(a, f3));
            if (wr) check("bus_wdata", bus_wdata, exp_wdata(wd, f3));
            if (stall) stall_cnt++;
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        if (rd && !wr) model_rd = exp_load(a, f3, rdata);
        @(negedge clk);
        check("done_stall", 32'(stall), 32'h0);
        check("done_en", 32'(bus_en), 32'h0);
        check("rd_data", rd_data, model_rd);
        check("stall_cycles", 32'(stall_cnt), 32'(waits + 2));
        @(posedge clk); #1;
        check("no_reissue", 32'(bus_en), 32'h0);
        if (release_bus) set_idle();
    endtask

    initial begin
        int t0;
        logic [2:0] f3;
        logic rd, wr;
        int sel;

        rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        addr = '0; wr_data = '0; inst = '0;
        set_idle();
        @(negedge clk);
        check("rst_en", 32'(bus_en), 32'h0);
        check("rst_we", 32'(bus_we), 32'h0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_be", 32'(bus_be), 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_rd", rd_data, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        access(32'h104, 32'h0, 32'hDEADBEEF, 3'b010, 1'b1, 1'b0, 2, 1'b1);
        access(32'h203, 32'h0, 32'h80112233, 3'b000, 1'b1, 1'b0, 1, 1'b1);
        access(32'h203, 32'h0, 32'h80112233, 3'b100, 1'b1, 1'b0, 0, 1'b1);
        access(32'h302, 32'h1234ABCD, 32'h55555555, 3'b001, 1'b0, 1'b1, 1, 1'b1);
        access(32'h101, 32'h0, 32'h0, 3'b010, 1'b1, 1'b0, 0, 1'b1);
        access(32'h103, 32'h0, 32'h0, 3'b001, 1'b1, 1'b0, 0, 1'b1);

        // Ack outside BUSY must be ignored
        bus_ack = 1'b1;
        @(negedge clk);
        check("idle_ack_en", 32'(bus_en), 32'h0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_stall", 32'(stall), 32'h0);
        check("idle_ack_rd", rd_data, model_rd);
        @(posedge clk); #1;

        // Reset in the middle of an access
        addr = 32'h400; inst = {17'h0, 3'b010, 12'h003}; memread = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_en", 32'(bus_en), 32'h1);
        #2 rst_n = 1'b0; set_idle();
        #1;
        check("mid_rst_en", 32'(bus_en), 32'h0);
        check("mid_rst_rd", rd_data, 32'h0);
        check("mid_rst_stall", 32'(stall), 32'h0);
        model_rd = 32'h0;
        t0 = txn_count;
        @(posedge clk); #1;
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("post_rst_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("post_rst_en", 32'(bus_en), 32'h0);
        check("post_rst_rd", rd_data, 32'h0);
        check("post_rst_txn", 32'(txn_count - t0), 32'h0);
        @(posedge clk); #1;

        // Back-to-back load then store, ack in the first BUSY cycle
        t0 = txn_count;
        access(32'h500, 32'h0, 32'h13579BDF, 3'b010, 1'b1, 1'b0, 0, 1'b0);
        access(32'h504, 32'hA5A5F00F, 32'h0, 3'b010, 1'b0, 1'b1, 0, 1'b1);
        @(negedge clk);
        check("b2b_txn", 32'(txn_count - t0), 32'h2);
        @(posedge clk); #1;

        // Randomized accesses against the reference model
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 3));
            rd = sel[0];
            wr = sel[1];
            f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            access($urandom, $urandom, $urandom, f3, rd, wr,
                   int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
        end
        set_idle();
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage that sits directly downstream of the execute stage.
- Consumes the execute result as the effective address, plus the store data, instruction and memread/memwrite controls.
- Runs one load or store per instruction over a single-outstanding req/ack data bus: byte-lane steering, load sign/zero extension, misalignment detection.
- Stalls the pipeline until the access completes.

Parameters:
- XLEN, 32, datapath and address width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_addr  in  XLEN  effective address (execute-stage result)
- i_wr_data  in  XLEN  store data (rs2)
- i_inst  in  32  instruction; f3 = i_inst[14:12]
- i_memread  in  1  load request
- i_memwrite  in  1  store request
- o_bus_en  out  1  bus request valid
- o_bus_we  out  1  1 = write
- o_bus_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  XLEN  lane-replicated store data
- i_bus_rdata  in  XLEN  read data, valid with ack
- i_bus_ack  in  1  access complete, one-cycle pulse
- o_rd_data  out  XLEN  formatted load result (registered)
- o_misaligned  out  1  misaligned access flag (combinational)
- o_stall  out  1  hold upstream pipeline (combinational)

Behaviour:
- Reset (i_rst=0, async): state=IDLE; all registered outputs are 0 (o_bus_en, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata, o_rd_data). Reset mid-access drops o_bus_en immediately; any later ack is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req = i_memread | i_memwrite. If both are set, the write wins.
  - Misalignment: halfword (f3[1:0]=01) with addr[0]=1; word (f3[1:0]=10) with addr[1:0]!=0.
  - req & misaligned: o_misaligned=1, o_stall=0, no bus access, stay IDLE.
  - req & aligned: o_stall=1. Latch address, f3, we, be and wdata into the bus registers. Go to BUSY; o_bus_en=1 from the next cycle.
  - No req: o_stall=0.
- BUSY:
  - o_stall=1; bus outputs are held stable until ack.
  - On i_bus_ack: o_bus_en<=0, go to DONE. For a load, o_rd_data<=formatted i_bus_rdata.
- DONE:
  - o_stall=0 for exactly one cycle; the upstream register advances at the end of this cycle. Next state is IDLE.
  - Inputs still showing the same instruction in DONE do not re-trigger an access.
- i_bus_ack outside BUSY is ignored.
- Minimum occupancy is 3 cycles (request, BUSY with ack, DONE); each bus wait cycle adds one.
- Byte enables:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<addr[1:0]
  - SW: 4'b1111
  - Loads use the same masks.
- Write data:
  - SB: {4{wr_data[7:0]}}
  - SH: {2{wr_data[15:0]}}
  - SW: wr_data
- Load format, using the latched addr[1:0]:
  - LB(000): sign-extend the selected byte
  - LBU(100): zero-extend the selected byte
  - LH(001): sign-extend the selected halfword
  - LHU(101): zero-extend the selected halfword
  - LW(010): word unchanged
  - Any other f3: zero-extend the selected byte.
- o_rd_data holds its value until the next completed load; stores do not change it.

Test Plan:
- LW addr=0x104, rdata=0xDEADBEEF, ack 2 cycles after en -> be=1111, bus_addr=0x104, stall high 4 cycles, o_rd_data=0xDEADBEEF in DONE.
- LB addr=0x203 and LBU addr=0x203, rdata=0x80112233 -> LB gives o_rd_data=0xFFFFFF80, LBU gives 0x00000080, be=1000.
- SH addr=0x302, wr_data=0x1234ABCD -> we=1, be=1100, wdata=0xABCDABCD, bus_addr=0x300; o_rd_data unchanged.
- LW addr=0x101 and LH addr=0x103 -> o_misaligned=1, o_stall=0, o_bus_en never asserted.
- i_rst pulsed low while BUSY, then ack -> o_bus_en=0 immediately, state IDLE, o_rd_data=0, ack ignored.
- Back-to-back LW then SW with ack in the first BUSY cycle -> 3-cycle occupancy each; no re-issue in DONE; exactly two bus transactions.
